sha256_msg_sched: RTL and testbench
===================================

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
- REQ-001 The block SHALL have no parameters; word width (32), block length (16 words) and round count (64) SHALL be fixed constants.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 rst  input  1  synchronous reset, active-high.
- REQ-004 in_valid  input  1  in_word holds a message word.
- REQ-005 in_ready  output  1  block accepts in_word this cycle.
- REQ-006 in_word  input  32  message word M[t], t=0..15, big-endian word order.
- REQ-007 w_valid  output  1  w_out holds schedule word W[t].
- REQ-008 w_ready  input  1  downstream round stage consumes w_out this cycle.
- REQ-009 w_out  output  32  schedule word W[t].
- REQ-010 w_idx  output  6  index t of w_out.
- REQ-011 w_last  output  1  high with w_valid when w_idx==63.

Function
- REQ-012 The block SHALL hold a 16-entry window of 32-bit words (W[t-16]..W[t-1]) and a 6-bit counter t.
- REQ-013 The block SHALL have states IDLE, LOAD and EXPAND; IDLE->LOAD on the first in_valid&in_ready; LOAD->EXPAND when word t=15 is accepted; EXPAND->IDLE when W[63] transfers (w_valid&w_ready&w_last).
- REQ-014 The output register SHALL be free when !w_valid || w_ready; a word SHALL load into it only when free.
- REQ-015 In IDLE/LOAD, in_ready SHALL equal "output register free"; in EXPAND, in_ready SHALL be 0.
- REQ-016 On input accept: w_out<=in_word, w_idx<=t, w_valid<=1, window shifts in in_word, t increments.
- REQ-017 In EXPAND, when free: w_out<=sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] mod 2^32, window shifts, t increments.
- REQ-018 sigma0(x)=ROTR7^ROTR18^SHR3; sigma1(x)=ROTR17^ROTR19^SHR10.
- REQ-019 Latency: a word SHALL appear on w_out the cycle after its acceptance/computation; throughput SHALL be one word per cycle when w_ready is held high.
- REQ-020 w_valid&&!w_ready SHALL hold w_out, w_idx, w_last stable; the window and t SHALL not advance.
- REQ-021 t SHALL not wrap past 63; after W[63] transfers, t SHALL be 0 and in_ready SHALL assert in the same cycle as the output register becomes free.
- REQ-022 A new block's M[0] SHALL be accepted in the cycle W[63] transfers (back-to-back blocks, no bubble).

Reset
- REQ-023 On rst: state=IDLE, t=0, w_valid=0, w_out=0, w_idx=0, w_last=0, window cleared; in_ready=1 in the following cycle.
- REQ-024 rst mid-block SHALL discard the partial block; no further words of it SHALL be emitted.

Configuration
- REQ-025 Macro SHA256_SCHED_ABORT_EN: when defined, input port abort (1 bit) SHALL exist; abort high SHALL act as REQ-023 (rst has priority; abort with in_valid SHALL drop that word).
- REQ-026 Without SHA256_SCHED_ABORT_EN, the port SHALL be absent and behaviour SHALL match REQ-012..024 exactly.

Structure
- REQ-027 Shared package sha256_pkg SHALL hold the constants (WORD_W=32, BLOCK_WORDS=16, ROUNDS=64), the state enum, and the sigma0/sigma1 functions.
- REQ-028 One combinational sub-module sha256_sched_word SHALL compute the REQ-017 sum from four window words.

Verification
- REQ-029 "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready=1 -> 64 consecutive words; W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB, w_last only on W63.
- REQ-030 Same block with w_ready toggling 1/0 each cycle -> identical word sequence, w_out stable while stalled, in_ready=0 throughout EXPAND.
- REQ-031 Two blocks back-to-back -> second block's M0 accepted in the W63 transfer cycle; second sequence correct.
- REQ-032 rst asserted after W40 -> next cycle w_valid=0, in_ready=1; new block restarts at w_idx=0.
- REQ-033 in_valid gaps during LOAD (one word every 3 cycles) -> w_idx 0..15 contiguous, no spurious w_valid.
- REQ-034 With SHA256_SCHED_ABORT_EN, abort at W20 -> same response as REQ-032.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and the SHA-256 small-sigma functions
// used by the message schedule.
package sha256_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned ROUNDS      = 64;
    localparam int unsigned IDX_W       = 6;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExpand
    } sched_state_e;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Combinational expansion of one schedule word:
// W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] (mod 2^32).
module sha256_sched_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_w2,
    input  logic [WORD_W-1:0] i_w7,
    input  logic [WORD_W-1:0] i_w15,
    input  logic [WORD_W-1:0] i_w16,
    output logic [WORD_W-1:0] o_sum
);

    assign o_sum = sigma1(i_w2) + i_w7 + sigma0(i_w15) + i_w16;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 message words, passes them through, then
// expands W[16..63] from a 16-word sliding window, one word per cycle with a
// valid/ready output register. Optional synchronous abort port enabled by
// the macro SHA256_SCHED_ABORT_EN.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef SHA256_SCHED_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_out,
    output logic [IDX_W-1:0]  w_idx,
    output logic              w_last
);

    localparam logic [IDX_W-1:0] LAST_LOAD  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);
    localparam int               WIN_TOP    = int'(BLOCK_WORDS) - 1;

    sched_state_e      r_state;
    sched_state_e      w_state_next;
    logic [IDX_W-1:0]  r_t;
    // r_win[15] is W[t-1], r_win[0] is W[t-16]
    logic [WORD_W-1:0] r_win [BLOCK_WORDS];
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_word;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_out_last;

    logic              w_clear;
    logic              w_free;
    logic              w_holds_last;
    logic              w_last_xfer;
    logic              w_accept;
    logic              w_expand;
    logic [WORD_W-1:0] w_sched;
    logic [WORD_W-1:0] w_next_word;

`ifdef SHA256_SCHED_ABORT_EN
    assign w_clear = rst || abort;
`else
    assign w_clear = rst;
`endif

    assign w_free       = !r_out_valid || w_ready;
    assign w_holds_last = r_out_valid && r_out_last;
    assign w_last_xfer  = w_holds_last && w_ready;

    // In EXPAND the input opens only in the cycle W[63] leaves, so the next
    // block's M[0] can follow with no bubble.
    assign in_ready    = w_free && ((r_state != StExpand) || w_holds_last);
    assign w_accept    = in_valid && in_ready;
    assign w_expand    = (r_state == StExpand) && w_free && !w_holds_last;
    assign w_next_word = w_accept ? in_word : w_sched;

    assign w_valid = r_out_valid;
    assign w_out   = r_out_word;
    assign w_idx   = r_out_idx;
    assign w_last  = r_out_last;

    sha256_sched_word u_word (
        .i_w2  (r_win[14]),
        .i_w7  (r_win[9]),
        .i_w15 (r_win[1]),
        .i_w16 (r_win[0]),
        .o_sum (w_sched)
    );

    // Next-state logic for the IDLE/LOAD/EXPAND controller.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_next = StLoad;
            end
            StLoad: begin
                if (w_accept && (r_t == LAST_LOAD)) w_state_next = StExpand;
            end
            StExpand: begin
                if (w_last_xfer) w_state_next = w_accept ? StLoad : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, counter, window and output register; clear wins over everything.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state     <= StIdle;
            r_t         <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            for (int i = 0; i <= WIN_TOP; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_accept || w_expand) begin
                r_out_valid <= 1'b1;
                r_out_word  <= w_next_word;
                r_out_idx   <= r_t;
                r_out_last  <= (r_t == LAST_ROUND);
                // Wraps to 0 only after W[63] has been produced.
                r_t         <= r_t + 1'b1;
                for (int i = 0; i < WIN_TOP; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[WIN_TOP] <= w_next_word;
            end else if (w_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: a reference schedule model fills
// a scoreboard queue per block, and a negedge monitor compares every valid
// output word against the queue head. Covers the abort port when built with
// SHA256_SCHED_ABORT_EN.
module tb_sha256_msg_sched;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] word;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
`ifdef SHA256_SCHED_ABORT_EN
    logic        abort;
`endif
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_out;
    logic [5:0]  w_idx;
    logic        w_last;

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    logic [31:0] cur_m [16];
    bit          toggle_en = 1'b0;
    bit          abc_chk   = 1'b0;

    sha256_msg_sched dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SHA256_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_idx    (w_idx),
        .w_last   (w_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: held high, or toggled every cycle when requested.
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) w_ready = !w_ready;
            else           w_ready = 1'b1;
        end
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic void push_block();
        logic [31:0] w [64];
        exp_t        e;
        for (int t = 0; t < 16; t++) w[t] = cur_m[t];
        for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            e.idx  = 6'(t);
            e.word = w[t];
            e.last = (t == 63);
            q.push_back(e);
        end
    endfunction

    function automatic void set_abc();
        for (int t = 0; t < 16; t++) cur_m[t] = 32'h0;
        cur_m[0]  = 32'h61626380;
        cur_m[15] = 32'h00000018;
    endfunction

    function automatic void set_rand();
        for (int t = 0; t < 16; t++) cur_m[t] = $urandom;
    endfunction

    // Output monitor: every valid word must match the scoreboard head and stay
    // there while stalled; the head is popped on transfer.
    always @(negedge clk) begin
        if (w_valid === 1'b1) begin
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL spurious_word: got idx=%0d word=%h, expected no output", w_idx, w_out);
            end
            if (q.size() != 0) begin
                total += 3;
                assert (w_out === q[0].word) else begin
                    bad++;
                    $error("FAIL w_out: got %h expected %h (idx %0d)", w_out, q[0].word, q[0].idx);
                end
                assert (w_idx === q[0].idx) else begin
                    bad++;
                    $error("FAIL w_idx: got %0d expected %0d", w_idx, q[0].idx);
                end
                assert (w_last === q[0].last) else begin
                    bad++;
                    $error("FAIL w_last: got %b expected %b (idx %0d)", w_last, q[0].last, q[0].idx);
                end
                if (w_ready === 1'b1) void'(q.pop_front());
            end
            if (w_idx >= 6'd15 && w_idx < 6'd63) begin
                total++;
                assert (in_ready === 1'b0) else begin
                    bad++;
                    $error("FAIL in_ready_expand: got %b expected 0 (idx %0d)", in_ready, w_idx);
                end
            end
            if (abc_chk && w_idx == 6'd16) begin
                total++;
                assert (w_out === 32'h61626380) else begin
                    bad++;
                    $error("FAIL abc_w16: got %h expected 61626380", w_out);
                end
            end
            if (abc_chk && w_idx == 6'd17) begin
                total++;
                assert (w_out === 32'h000F0000) else begin
                    bad++;
                    $error("FAIL abc_w17: got %h expected 000f0000", w_out);
                end
            end
            if (abc_chk && w_idx == 6'd63) begin
                total++;
                assert (w_out === 32'h12B1EDEB) else begin
                    bad++;
                    $error("FAIL abc_w63: got %h expected 12b1edeb", w_out);
                end
            end
        end
    end

    // Feed cur_m[0..15], idling `gap` cycles after each accepted word.
    task automatic send_words(input int gap, input bit chk_b2b);
        for (int i = 0; i < 16; i++) begin
            bit ok;
            ok       = 1'b0;
            in_valid = 1'b1;
            in_word  = cur_m[i];
            for (int n = 0; n < 300 && !ok; n++) begin
                @(negedge clk);
                if (in_ready === 1'b1) begin
                    ok = 1'b1;
                    if (i == 0 && chk_b2b) begin
                        total++;
                        assert ((w_valid && w_ready && w_last) === 1'b1) else begin
                            bad++;
                            $error("FAIL b2b_m0: M0 accepted with valid=%b ready=%b last=%b, expected W63 transfer",
                                   w_valid, w_ready, w_last);
                        end
                    end
                end
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            total++;
            assert (ok) else begin
                bad++;
                $error("FAIL accept_timeout: word %0d got no in_ready, expected accept", i);
            end
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Wait for the scoreboard to empty, then expect an idle, ready block.
    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (q.size() == 0) ok = 1'b1;
        end
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL drain_timeout: %0d words outstanding, expected 0", q.size());
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total += 2;
        assert (w_valid === 1'b0) else begin
            bad++;
            $error("FAIL idle_valid: got %b expected 0", w_valid);
        end
        assert (in_ready === 1'b1) else begin
            bad++;
            $error("FAIL idle_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_transfer(input logic [5:0] idx);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (w_valid === 1'b1 && w_ready === 1'b1 && w_idx == idx) ok = 1'b1;
        end
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL wait_idx: W%0d never transferred, expected transfer", idx);
        end
    endtask

    task automatic check_cleared(input string tag);
        @(negedge clk);
        total += 2;
        assert (w_valid === 1'b0) else begin
            bad++;
            $error("FAIL %s_valid: got %b expected 0", tag, w_valid);
        end
        assert (in_ready === 1'b1) else begin
            bad++;
            $error("FAIL %s_ready: got %b expected 1", tag, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
`ifdef SHA256_SCHED_ABORT_EN
        abort    = 1'b0;
`endif
        in_valid = 1'b0;
        in_word  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        total += 5;
        assert (w_valid === 1'b0) else begin bad++; $error("FAIL rst_valid: got %b expected 0", w_valid); end
        assert (w_out === 32'h0) else begin bad++; $error("FAIL rst_out: got %h expected 0", w_out); end
        assert (w_idx === 6'd0) else begin bad++; $error("FAIL rst_idx: got %0d expected 0", w_idx); end
        assert (w_last === 1'b0) else begin bad++; $error("FAIL rst_last: got %b expected 0", w_last); end
        assert (in_ready === 1'b1) else begin bad++; $error("FAIL rst_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;

        // "abc" block, w_ready held high
        abc_chk = 1'b1;
        set_abc();
        push_block();
        send_words(0, 1'b0);
        drain();

        // Same block with w_ready toggling
        toggle_en = 1'b1;
        push_block();
        send_words(0, 1'b0);
        drain();
        toggle_en = 1'b0;
        abc_chk   = 1'b0;
        @(posedge clk);
        #1;

        // Two blocks back-to-back
        set_rand();
        push_block();
        send_words(0, 1'b0);
        set_rand();
        push_block();
        send_words(0, 1'b1);
        drain();

        // Gapped LOAD: one word every 3 cycles
        set_rand();
        push_block();
        send_words(2, 1'b0);
        drain();

        // Reset mid-block after W40, then a fresh block
        set_rand();
        push_block();
        send_words(0, 1'b0);
        wait_transfer(6'd40);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        check_cleared("rst_mid");
        set_abc();
        push_block();
        send_words(0, 1'b0);
        drain();

`ifdef SHA256_SCHED_ABORT_EN
        // Abort at W20, with a word offered in the abort cycle
        set_rand();
        push_block();
        send_words(0, 1'b0);
        wait_transfer(6'd20);
        @(posedge clk);
        #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        check_cleared("abort");
        set_rand();
        push_block();
        send_words(0, 1'b0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
